mul_acc_pipe: RTL and testbench

- Parametrised successor to the team's fixed 16x16 registered multiplier.
- Adds configurable operand widths and configurable pipeline latency.
- Adds a per-transaction signed/unsigned mode and an optional multiply-accumulate mode.
- Adds a valid/ready output handshake with full-pipeline backpressure.
- Sits between streaming datapath stages, e.g. filter taps and dot-product engines.

---
 rtl/mul_acc_pipe_if.sv | 35 +++
 rtl/mul_acc_pipe.sv | 168 ++++++++++++++++
 tb/tb_mul_acc_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_acc_pipe_if.sv
// mul_acc_pipe_if: streaming bus for mul_acc_pipe.
//   Upstream side : ain, bin, sgn, acc, vldin -> rdyin
//   Downstream    : vldout, dout, ovf         <- rdyout
// Modports:
//   master - the environment that drives operands and consumes results.
//   slave  - the multiplier/accumulator itself.
// AW/BW/GW must match the parameters of the attached mul_acc_pipe.
interface mul_acc_pipe_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned BW = 16,
    parameter int unsigned GW = 8
);
    localparam int unsigned RW = AW + BW + GW;

    logic [AW-1:0] ain;
    logic [BW-1:0] bin;
    logic          sgn;
    logic          acc;
    logic          vldin;
    logic          rdyin;
    logic          vldout;
    logic          rdyout;
    logic [RW-1:0] dout;
    logic          ovf;

    modport master (
        output ain, bin, sgn, acc, vldin, rdyout,
        input  rdyin, vldout, dout, ovf
    );

    modport slave (
        input  ain, bin, sgn, acc, vldin, rdyout,
        output rdyin, vldout, dout, ovf
    );
endinterface

// File: rtl/mul_acc_pipe.sv
// mul_acc_pipe: pipelined AWxBW multiplier with optional accumulate.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset.
//   bus.ain/bin: operands; bus.sgn selects two's complement vs unsigned.
//   bus.acc    : 1 = add product to the last loaded dout, 0 = load product.
//   bus.vldin/rdyin   : input handshake (rdyin is combinational).
//   bus.vldout/rdyout : output handshake; a held output stalls the whole pipe.
//   bus.dout/ovf      : RW = AW+BW+GW bit result and its overflow flag.
// Latency from acceptance to vldout is LAT-1 edges (LAT in 2..8).
module mul_acc_pipe #(
    parameter int unsigned AW  = 16,
    parameter int unsigned BW  = 16,
    parameter int unsigned GW  = 8,
    parameter int unsigned LAT = 2
) (
    input logic           clk,
    input logic           rst_n,
    mul_acc_pipe_if.slave bus
);
    localparam int unsigned RW = AW + BW + GW;

    if (LAT < 2 || LAT > 8) begin : g_bad_lat
        $error("mul_acc_pipe: LAT must be in 2..8");
    end

    logic                 adv;

    logic                 s1_vld_q;
    logic [AW-1:0]        s1_a_q;
    logic [BW-1:0]        s1_b_q;
    logic                 s1_sgn_q;
    logic                 s1_acc_q;

    logic signed [AW:0]      a_x;
    logic signed [BW:0]      b_x;
    logic signed [AW+BW+1:0] p_full;
    logic [RW-1:0]           prod_ext;

    logic                 fin_vld;
    logic [RW-1:0]        fin_prod;
    logic                 fin_sgn;
    logic                 fin_acc;

    logic [RW:0]          sum;
    logic                 vldout_q, vldout_d;
    logic [RW-1:0]        dout_q, dout_d;
    logic                 ovf_q, ovf_d;

    // Whole-pipe stall: nothing moves while a result waits on the output.
    always_comb begin
        adv = !vldout_q || bus.rdyout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_sgn_q <= 1'b0;
            s1_acc_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q <= bus.vldin;
            if (bus.vldin) begin
                s1_a_q   <= bus.ain;
                s1_b_q   <= bus.bin;
                s1_sgn_q <= bus.sgn;
                s1_acc_q <= bus.acc;
            end
        end
    end

    // One extra operand bit makes a single signed multiplier serve both
    // modes: the bit is the sign for sgn=1 and zero for sgn=0. The exact
    // product is then sign-extended (or truncated when GW<2) to RW.
    always_comb begin
        a_x      = {s1_sgn_q & s1_a_q[AW-1], s1_a_q};
        b_x      = {s1_sgn_q & s1_b_q[BW-1], s1_b_q};
        p_full   = a_x * b_x;
        prod_ext = RW'(p_full);
    end

    if (LAT == 2) begin : g_direct
        always_comb begin
            fin_vld  = s1_vld_q;
            fin_prod = prod_ext;
            fin_sgn  = s1_sgn_q;
            fin_acc  = s1_acc_q;
        end
    end else begin : g_delay
        localparam int unsigned ND = LAT - 2;

        logic          d_vld_q  [ND];
        logic [RW-1:0] d_prod_q [ND];
        logic          d_sgn_q  [ND];
        logic          d_acc_q  [ND];

        // Entry 0 registers the product; the rest are plain delay stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < ND; i++) begin
                    d_vld_q[i]  <= 1'b0;
                    d_prod_q[i] <= '0;
                    d_sgn_q[i]  <= 1'b0;
                    d_acc_q[i]  <= 1'b0;
                end
            end else if (adv) begin
                d_vld_q[0]  <= s1_vld_q;
                d_prod_q[0] <= prod_ext;
                d_sgn_q[0]  <= s1_sgn_q;
                d_acc_q[0]  <= s1_acc_q;
                for (int unsigned i = 1; i < ND; i++) begin
                    d_vld_q[i]  <= d_vld_q[i-1];
                    d_prod_q[i] <= d_prod_q[i-1];
                    d_sgn_q[i]  <= d_sgn_q[i-1];
                    d_acc_q[i]  <= d_acc_q[i-1];
                end
            end
        end

        always_comb begin
            fin_vld  = d_vld_q[ND-1];
            fin_prod = d_prod_q[ND-1];
            fin_sgn  = d_sgn_q[ND-1];
            fin_acc  = d_acc_q[ND-1];
        end
    end

    // Output stage. The accumulate base is always dout_q, i.e. the last
    // loaded value whether or not it has been consumed downstream.
    always_comb begin
        sum      = {1'b0, dout_q} + {1'b0, fin_prod};
        vldout_d = fin_vld;
        dout_d   = dout_q;
        ovf_d    = ovf_q;
        if (fin_vld) begin
            if (fin_acc) begin
                dout_d = sum[RW-1:0];
                if (fin_sgn) begin
                    ovf_d = (dout_q[RW-1] == fin_prod[RW-1]) &&
                            (sum[RW-1] != dout_q[RW-1]);
                end else begin
                    ovf_d = sum[RW];
                end
            end else begin
                dout_d = fin_prod;
                ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vldout_q <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vldout_q <= vldout_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        bus.rdyin  = adv;
        bus.vldout = vldout_q;
        bus.dout   = dout_q;
        bus.ovf    = ovf_q;
    end
endmodule

// File: tb/tb_mul_acc_pipe.sv
// tb_mul_acc_pipe: scoreboard bench for mul_acc_pipe.
// Two instances share the stimulus bus: u_dut2 (LAT=2) and u_dut4 (LAT=4);
// 'sel' steers vldin to one of them. Each accepted input pushes its
// hand-computed result onto that instance's queue; per-instance monitors pop
// and compare on every output handshake.
module tb_mul_acc_pipe;
    typedef struct packed {
        logic [39:0] d;
        logic        o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    logic [15:0] st_ain = '0;
    logic [15:0] st_bin = '0;
    logic        st_sgn = 1'b0;
    logic        st_acc = 1'b0;
    logic        st_vld = 1'b0;
    logic        st_rdyout = 1'b1;
    logic        sel = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;

    exp_t        q2[$];
    exp_t        q4[$];
    exp_t        e2, e4;
    int          last_acc_cyc = 0;
    int          first4 = -1;
    int          run4 = 0;
    int          maxrun4 = 0;
    logic        prev4 = 1'b0;

    mul_acc_pipe_if #(.AW(16), .BW(16), .GW(8)) b2 ();
    mul_acc_pipe_if #(.AW(16), .BW(16), .GW(8)) b4 ();

    assign b2.ain    = st_ain;
    assign b2.bin    = st_bin;
    assign b2.sgn    = st_sgn;
    assign b2.acc    = st_acc;
    assign b2.vldin  = st_vld & ~sel;
    assign b2.rdyout = st_rdyout;
    assign b4.ain    = st_ain;
    assign b4.bin    = st_bin;
    assign b4.sgn    = st_sgn;
    assign b4.acc    = st_acc;
    assign b4.vldin  = st_vld & sel;
    assign b4.rdyout = st_rdyout;

    mul_acc_pipe #(.AW(16), .BW(16), .GW(8), .LAT(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    mul_acc_pipe #(.AW(16), .BW(16), .GW(8), .LAT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected none", nm);
    endtask

    // Scoreboard monitors: compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && b2.vldout && st_rdyout) begin
            if (q2.size() == 0) begin
                fail_now("dut2_unexpected_output");
            end else begin
                e2 = q2.pop_front();
                chk("dut2_dout", b2.dout, e2.d);
                chk("dut2_ovf", 40'(b2.ovf), 40'(e2.o));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b4.vldout) begin
            if (first4 < 0) first4 = cyc;
            run4 = prev4 ? run4 + 1 : 1;
            if (run4 > maxrun4) maxrun4 = run4;
        end
        prev4 = rst_n && b4.vldout;
        if (rst_n && b4.vldout && st_rdyout) begin
            if (q4.size() == 0) begin
                fail_now("dut4_unexpected_output");
            end else begin
                e4 = q4.pop_front();
                chk("dut4_dout", b4.dout, e4.d);
                chk("dut4_ovf", 40'(b4.ovf), 40'(e4.o));
            end
        end
    end

    // Present one input and wait (bounded) for acceptance. Returns #1 after
    // the accepting edge so consecutive calls stream back to back.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic ac,
                        input logic [39:0] ed, input logic eo, input bit push);
        bit done;
        done   = 1'b0;
        st_ain = a;
        st_bin = b;
        st_sgn = s;
        st_acc = ac;
        st_vld = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (sel ? b4.rdyin : b2.rdyin) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                last_acc_cyc = cyc;
                if (push) begin
                    if (sel) q4.push_back('{d: ed, o: eo});
                    else     q2.push_back('{d: ed, o: eo});
                end
            end
        end
        if (!done) fail_now("send_accept");
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && (q2.size() != 0 || q4.size() != 0); k++) begin
            @(posedge clk);
            #1;
        end
        if (q2.size() != 0 || q4.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1, "watchdog");
    end

    logic [39:0] held;
    int          t0;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_vldout2", 40'(b2.vldout), 40'd0);
        chk("rst_dout2", b2.dout, 40'd0);
        chk("rst_ovf2", 40'(b2.ovf), 40'd0);
        chk("rst_rdyin2", 40'(b2.rdyin), 40'd1);
        chk("rst_vldout4", 40'(b4.vldout), 40'd0);
        chk("rst_dout4", b4.dout, 40'd0);

        // Unsigned basic, LAT=2
        send(16'd3, 16'd5, 1'b0, 1'b0, 40'd15, 1'b0, 1'b1);
        st_vld = 1'b0;
        chk("basic_vld_before", 40'(b2.vldout), 40'd0);
        @(posedge clk);
        #1;
        chk("basic_vld", 40'(b2.vldout), 40'd1);
        chk("basic_dout", b2.dout, 40'd15);
        @(posedge clk);
        #1;
        chk("basic_vld_drop", 40'(b2.vldout), 40'd0);

        // Width extremes
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'h00FFFE0001, 1'b0, 1'b1);
        send(16'hFFFE, 16'h0003, 1'b1, 1'b0, 40'hFFFFFFFFFA, 1'b0, 1'b1);
        st_vld = 1'b0;
        wait_drain();

        // Back-to-back on the LAT=4 instance
        sel = 1'b1;
        first4 = -1;
        maxrun4 = 0;
        t0 = 0;
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 16'(i), 1'b0, 1'b0, 40'(i * i), 1'b0, 1'b1);
            if (i == 1) t0 = last_acc_cyc;
        end
        st_vld = 1'b0;
        wait_drain();
        chk("b2b_latency", 40'(first4 - t0), 40'd3);
        chk("b2b_contiguous", 40'(maxrun4), 40'd8);
        sel = 1'b0;

        // Backpressure mid-stream on the LAT=2 instance
        fork
            begin
                send(16'd2,  16'd3,  1'b0, 1'b0, 40'd6,   1'b0, 1'b1);
                send(16'd4,  16'd5,  1'b0, 1'b0, 40'd20,  1'b0, 1'b1);
                send(16'd6,  16'd7,  1'b0, 1'b0, 40'd42,  1'b0, 1'b1);
                send(16'd8,  16'd9,  1'b0, 1'b0, 40'd72,  1'b0, 1'b1);
                send(16'd10, 16'd11, 1'b0, 1'b0, 40'd110, 1'b0, 1'b1);
                send(16'd12, 16'd13, 1'b0, 1'b0, 40'd156, 1'b0, 1'b1);
                st_vld = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                st_rdyout = 1'b0;
                held = b2.dout;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("stall_rdyin", 40'(b2.rdyin), 40'd0);
                    chk("stall_dout_held", b2.dout, held);
                    chk("stall_vldout", 40'(b2.vldout), 40'd1);
                    @(posedge clk);
                    #1;
                end
                st_rdyout = 1'b1;
            end
        join
        wait_drain();

        // Accumulate chain, unsigned wrap, mixed-sign chains
        send(16'd10,    16'd10,    1'b0, 1'b0, 40'd100,         1'b0, 1'b1);
        send(16'd10,    16'd20,    1'b0, 1'b1, 40'd300,         1'b0, 1'b1);
        send(16'd20,    16'd15,    1'b0, 1'b1, 40'd600,         1'b0, 1'b1);
        send(16'hFFFF,  16'h0001,  1'b1, 1'b0, 40'hFFFFFFFFFF,  1'b0, 1'b1);
        send(16'd2,     16'd3,     1'b0, 1'b1, 40'h0000000005,  1'b1, 1'b1);
        send(16'd1,     16'd1,     1'b0, 1'b1, 40'h0000000006,  1'b0, 1'b1);
        send(16'hFFFF,  16'h0001,  1'b1, 1'b0, 40'hFFFFFFFFFF,  1'b0, 1'b1);
        send(16'hFFFE,  16'h0003,  1'b1, 1'b1, 40'hFFFFFFFFF9,  1'b0, 1'b1);
        st_vld = 1'b0;
        wait_drain();

        // Reset with two transactions in flight
        st_rdyout = 1'b0;
        send(16'd100, 16'd100, 1'b0, 1'b1, 40'd0, 1'b0, 1'b0);
        send(16'd50,  16'd50,  1'b0, 1'b0, 40'd0, 1'b0, 1'b0);
        st_vld = 1'b0;
        chk("inflight_vldout", 40'(b2.vldout), 40'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vldout", 40'(b2.vldout), 40'd0);
        chk("midrst_dout", b2.dout, 40'd0);
        chk("midrst_ovf", 40'(b2.ovf), 40'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        st_rdyout = 1'b1;
        @(posedge clk);
        #1;
        send(16'd7, 16'd7, 1'b0, 1'b1, 40'd49, 1'b0, 1'b1);
        st_vld = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
